// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : div_arbiter
// Brief    : Round-robin sharing of one iterative divider among NREQ
//            requesters, with divide-by-zero screening and a done pulse.
// Revision : 1.0
// ============================================================================

module div_arbiter #(
  parameter int NREQ = 4,
  parameter int BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*BITS-1:0] req_dividend,
  input  logic [NREQ*BITS-1:0] req_divisor,
  output logic [NREQ-1:0]      done,
  output logic [BITS-1:0]      quotient,
  output logic [BITS-1:0]      remainder,
  output logic                 div_by_zero,
  output logic                 busy,
  output logic                 div_start,
  output logic [BITS-1:0]      div_dividend,
  output logic [BITS-1:0]      div_divisor,
  input  logic                 div_finished,
  input  logic [BITS-1:0]      div_result,
  input  logic [BITS-1:0]      div_rest
);

  localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_IW = c_PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_PW-1:0]   r_gnt, w_gnt_nxt;
  logic [c_PW-1:0]   r_ptr, w_ptr_nxt;
  logic [NREQ-1:0]   r_served, w_served_nxt;
  logic              r_zero, w_zero_nxt;
  logic [NREQ-1:0]   r_done, w_done_nxt;
  logic [BITS-1:0]   r_quot, w_quot_nxt;
  logic [BITS-1:0]   r_rem, w_rem_nxt;
  logic              r_dbz, w_dbz_nxt;
  logic              r_start, w_start_nxt;
  logic [BITS-1:0]   r_dvd, w_dvd_nxt;
  logic [BITS-1:0]   r_dvs, w_dvs_nxt;

  logic [NREQ-1:0]   w_elig;
  logic              w_found;
  logic [c_PW-1:0]   w_gnt;
  logic [c_IW-1:0]   w_idx;
  logic [BITS-1:0]   w_sel_dvd;
  logic [BITS-1:0]   w_sel_dvs;

  // A requester already answered stays ineligible until it drops req once.
  assign w_elig       = req & ~r_served;
  assign w_served_nxt = req & (r_served | w_done_nxt);

  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + c_IW'(k);
      if (w_idx >= c_IW'(NREQ)) w_idx = w_idx - c_IW'(NREQ);
      if (!w_found && w_elig[w_idx[c_PW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[c_PW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_dvd = '0;
    w_sel_dvs = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt == c_PW'(i)) begin
        w_sel_dvd = req_dividend[i*BITS +: BITS];
        w_sel_dvs = req_divisor[i*BITS +: BITS];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_zero_nxt  = r_zero;
    w_done_nxt  = '0;
    w_quot_nxt  = r_quot;
    w_rem_nxt   = r_rem;
    w_dbz_nxt   = r_dbz;
    w_start_nxt = 1'b0;
    w_dvd_nxt   = r_dvd;
    w_dvs_nxt   = r_dvs;
    case (r_state)
      S_IDLE: begin
        // The divider has no reset, so never issue until it reports finished.
        if (w_found && div_finished) begin
          w_gnt_nxt = w_gnt;
          w_ptr_nxt = (w_gnt == c_PW'(NREQ-1)) ? '0 : w_gnt + c_PW'(1);
          w_dvd_nxt = w_sel_dvd;
          w_dvs_nxt = w_sel_dvs;
          if (w_sel_dvs == '0) begin
            w_zero_nxt  = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_zero_nxt  = 1'b0;
            w_start_nxt = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: w_state_nxt = S_RUN;
      S_RUN: begin
        if (r_zero) begin
          w_quot_nxt        = '0;
          w_rem_nxt         = r_dvd;
          w_dbz_nxt         = 1'b1;
          w_done_nxt[r_gnt] = 1'b1;
          w_state_nxt       = S_RESP;
        end else if (div_finished) begin
          w_quot_nxt        = div_result;
          w_rem_nxt         = div_rest;
          w_dbz_nxt         = 1'b0;
          w_done_nxt[r_gnt] = 1'b1;
          w_state_nxt       = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_ptr    <= '0;
      r_served <= '0;
      r_zero   <= 1'b0;
      r_done   <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dbz    <= 1'b0;
      r_start  <= 1'b0;
      r_dvd    <= '0;
      r_dvs    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_ptr    <= w_ptr_nxt;
      r_served <= w_served_nxt;
      r_zero   <= w_zero_nxt;
      r_done   <= w_done_nxt;
      r_quot   <= w_quot_nxt;
      r_rem    <= w_rem_nxt;
      r_dbz    <= w_dbz_nxt;
      r_start  <= w_start_nxt;
      r_dvd    <= w_dvd_nxt;
      r_dvs    <= w_dvs_nxt;
    end
  end

  assign done         = r_done;
  assign quotient     = r_quot;
  assign remainder    = r_rem;
  assign div_by_zero  = r_dbz;
  assign busy         = (r_state != S_IDLE);
  assign div_start    = r_start;
  assign div_dividend = r_dvd;
  assign div_divisor  = r_dvs;

endmodule

`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_arbiter
// Brief    : Directed and randomized bench for div_arbiter with an iterative
//            divider model and a transaction-level reference.
// Revision : 1.0
// ============================================================================

module tb_div_arbiter;

  localparam int NREQ = 4;
  localparam int BITS = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*BITS-1:0] req_dividend = '0;
  logic [NREQ*BITS-1:0] req_divisor = '0;
  logic [NREQ-1:0]      done;
  logic [BITS-1:0]      quotient, remainder, div_dividend, div_divisor;
  logic                 div_by_zero, busy, div_start;
  logic                 div_finished = 1'b1;
  logic [BITS-1:0]      div_result = '0;
  logic [BITS-1:0]      div_rest = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  div_arbiter #(.NREQ(NREQ), .BITS(BITS)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .busy(busy), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_finished(div_finished), .div_result(div_result), .div_rest(div_rest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Iterative divider: BITS cycles after sampling start, no reset, garbage while running.
  int dv_cnt = 0;
  logic [BITS-1:0] dv_q = '0, dv_r = '0;
  always @(posedge clk) begin
    if (div_start) begin
      dv_cnt       <= BITS;
      div_finished <= 1'b0;
      dv_q         <= (div_divisor == '0) ? '1 : div_dividend / div_divisor;
      dv_r         <= (div_divisor == '0) ? '1 : div_dividend % div_divisor;
      div_result   <= $urandom;
      div_rest     <= $urandom;
    end else if (dv_cnt > 0) begin
      dv_cnt <= dv_cnt - 1;
      if (dv_cnt == 1) begin
        div_finished <= 1'b1;
        div_result   <= dv_q;
        div_rest     <= dv_r;
      end else begin
        div_result <= $urandom;
        div_rest   <= $urandom;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: an operation is a timeline measured in edges since its grant.
  bit              m_op;
  int              m_age, m_done_age, m_g, m_ptr;
  logic [BITS-1:0] m_a, m_b;
  bit              m_zero;
  bit              m_served [NREQ];
  logic [NREQ-1:0] e_done;
  logic [BITS-1:0] e_q, e_rem, e_dvd, e_dvs;
  logic            e_dbz, e_busy, e_start;

  task automatic model_reset();
    m_op = 0; m_age = 0; m_done_age = 0; m_g = 0; m_ptr = 0;
    m_a = '0; m_b = '0; m_zero = 0;
    for (int i = 0; i < NREQ; i++) m_served[i] = 0;
    e_done = '0; e_q = '0; e_rem = '0; e_dvd = '0; e_dvs = '0;
    e_dbz = 0; e_busy = 0; e_start = 0;
  endtask

  task automatic model_step();
    logic [NREQ-1:0] new_done;
    int idx;
    bit found;
    new_done = '0;
    found = 0;
    e_start = 0;
    e_done = '0;
    if (m_op) begin
      m_age++;
      if (m_age == m_done_age) begin
        new_done[m_g] = 1'b1;
        e_done = new_done;
        e_q    = m_zero ? '0 : m_a / m_b;
        e_rem  = m_zero ? m_a : m_a % m_b;
        e_dbz  = m_zero;
      end
      if (m_age == m_done_age + 1) m_op = 0;
    end else if (div_finished) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (!found && req[idx] && !m_served[idx]) begin
          found = 1;
          m_g = idx;
        end
      end
      if (found) begin
        m_op       = 1;
        m_age      = 0;
        m_a        = req_dividend[m_g*BITS +: BITS];
        m_b        = req_divisor[m_g*BITS +: BITS];
        m_zero     = (m_b == '0);
        m_done_age = m_zero ? 1 : BITS + 2;
        m_ptr      = (m_g + 1) % NREQ;
        e_dvd      = m_a;
        e_dvs      = m_b;
        e_start    = !m_zero;
      end
    end
    for (int i = 0; i < NREQ; i++) m_served[i] = req[i] && (m_served[i] || new_done[i]);
    e_busy = m_op;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!reset) model_reset();
      chk("cyc_done", done, e_done);
      chk("cyc_busy", busy, e_busy);
      chk("cyc_start", div_start, e_start);
      chk("cyc_dvd", div_dividend, e_dvd);
      chk("cyc_dvs", div_divisor, e_dvs);
      chk("cyc_quot", quotient, e_q);
      chk("cyc_rem", remainder, e_rem);
      chk("cyc_dbz", div_by_zero, e_dbz);
      if (reset) model_step();
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int i, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                        output logic [BITS-1:0] q, output logic [BITS-1:0] r,
                        output logic z, output int lat, output bit any_start);
    int g_cyc, n;
    req_dividend[i*BITS +: BITS] = a;
    req_divisor[i*BITS +: BITS]  = b;
    req[i] = 1'b1;
    any_start = 0; lat = -1; q = '0; r = '0; z = 1'b0; n = 0;
    do begin step(); n++; any_start |= div_start; end while (!busy && n < 200);
    chk("grant_wait", busy, 1);
    g_cyc = cyc;
    n = 0;
    while (!done[i] && n < 200) begin step(); n++; any_start |= div_start; end
    chk("done_wait", done[i], 1);
    lat = cyc - g_cyc;
    q = quotient; r = remainder; z = div_by_zero;
    req[i] = 1'b0;
    step();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    req = '0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  function automatic logic [BITS-1:0] rand_opnd(input bit is_divisor);
    int s;
    logic [BITS-1:0] v;
    s = $urandom_range(0, 9);
    if (is_divisor) begin
      if (s <= 1)      v = '0;
      else if (s == 2) v = 1;
      else if (s == 3) v = '1;
      else if (s == 4) v = $urandom_range(1, 20);
      else             v = $urandom;
    end else begin
      if (s == 0)      v = '1;
      else if (s == 1) v = $urandom_range(0, 20);
      else             v = $urandom;
    end
    return v;
  endfunction

  initial begin
    logic [BITS-1:0] q, r;
    logic z;
    int lat, n, dcount, waited;
    bit s;
    int order[$];
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    bit dropped[NREQ];
    int ast[NREQ];
    int acnt[NREQ];

    #1 reset = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start", div_start, 0);
    chk("rst_quot", quotient, 0);
    reset = 1'b1;
    step();

    run_op(0, 100, 7, q, r, z, lat, s);
    chk("single_lat", lat, 34);
    chk("single_quot", q, 14);
    chk("single_rem", r, 2);
    chk("single_dbz", z, 0);
    chk("single_start", s, 1);

    run_op(2, 55, 0, q, r, z, lat, s);
    chk("dbz_lat", lat, 1);
    chk("dbz_quot", q, 0);
    chk("dbz_rem", r, 55);
    chk("dbz_flag", z, 1);
    chk("dbz_nostart", s, 0);

    run_op(1, 32'hFFFF_FFFF, 1, q, r, z, lat, s);
    chk("max_quot", q, 32'hFFFF_FFFF);
    chk("max_rem", r, 0);
    run_op(3, 5, 9, q, r, z, lat, s);
    chk("small_quot", q, 0);
    chk("small_rem", r, 5);

    // Held request: exactly one done, re-armed only after req drops.
    req_dividend[1*BITS +: BITS] = 20;
    req_divisor[1*BITS +: BITS]  = 3;
    req[1] = 1'b1;
    n = 0;
    while (!done[1] && n < 200) begin step(); n++; end
    chk("held_first", done[1], 1);
    dcount = 0;
    repeat (6) begin step(); if (done[1]) dcount++; end
    chk("held_extra", dcount, 0);
    chk("held_idle", busy, 0);
    req[1] = 1'b0;
    step();
    req[1] = 1'b1;
    n = 0;
    while (!done[1] && n < 200) begin step(); n++; end
    chk("held_second", done[1], 1);
    chk("held_quot", quotient, 6);
    chk("held_rem", remainder, 2);
    req[1] = 1'b0;
    step();

    // Round-robin fairness with every requester continuously re-raising.
    pulse_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_dividend[i*BITS +: BITS] = 1000;
      req_divisor[i*BITS +: BITS]  = 10;
      dropped[i] = 0;
    end
    req = '1;
    n = 0;
    while (order.size() < 6 && n < 400) begin
      step(); n++;
      for (int i = 0; i < NREQ; i++) if (dropped[i]) begin req[i] = 1'b1; dropped[i] = 0; end
      for (int i = 0; i < NREQ; i++) begin
        if (done[i] && order.size() < 6) begin
          chk("rr_order", i, exp_order[order.size()]);
          chk("rr_quot", quotient, 100);
          chk("rr_rem", remainder, 0);
          order.push_back(i);
          req[i] = 1'b0;
          dropped[i] = 1;
        end
      end
    end
    chk("rr_count", order.size(), 6);
    req = '0;
    n = 0;
    while (busy && n < 200) begin step(); n++; end
    chk("rr_idle", busy, 0);
    step();

    // Reset in the middle of a division; the divider keeps running.
    req_dividend[0*BITS +: BITS] = 1000;
    req_divisor[0*BITS +: BITS]  = 7;
    req[0] = 1'b1;
    n = 0;
    while (!busy && n < 200) begin step(); n++; end
    chk("rstrun_grant", busy, 1);
    repeat (10) step();
    reset = 1'b0;
    req = '0;
    #1;
    chk("rstrun_done", done, 0);
    chk("rstrun_busy", busy, 0);
    step(); step();
    reset = 1'b1;
    req_dividend[3*BITS +: BITS] = 9;
    req_divisor[3*BITS +: BITS]  = 4;
    req[3] = 1'b1;
    waited = 0;
    n = 0;
    while (!busy && n < 200) begin
      if (!div_finished) waited++;
      step(); n++;
    end
    chk("rstrun_waited", (waited > 0), 1);
    n = 0;
    while (!done[3] && n < 200) begin step(); n++; end
    chk("rstrun_done3", done[3], 1);
    chk("rstrun_quot", quotient, 2);
    chk("rstrun_rem", remainder, 1);
    req[3] = 1'b0;
    step();

    // Randomized requesters, including abandoned requests and operand wiggles.
    for (int i = 0; i < NREQ; i++) begin ast[i] = 0; acnt[i] = 0; end
    repeat (1500) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        case (ast[i])
          0: if ($urandom_range(0, 7) == 0) begin
               req_dividend[i*BITS +: BITS] = rand_opnd(0);
               req_divisor[i*BITS +: BITS]  = rand_opnd(1);
               req[i] = 1'b1;
               ast[i] = 1;
             end
          1: if (done[i]) begin
               ast[i]  = 2;
               acnt[i] = $urandom_range(0, 3);
             end else if ($urandom_range(0, 99) == 0) begin
               req[i]  = 1'b0;
               ast[i]  = 3;
               acnt[i] = 60;
             end else if ($urandom_range(0, 15) == 0) begin
               req_dividend[i*BITS +: BITS] = rand_opnd(0);
               req_divisor[i*BITS +: BITS]  = rand_opnd(1);
             end
          2: if (acnt[i] == 0) begin req[i] = 1'b0; ast[i] = 0; end
             else acnt[i]--;
          default: if (acnt[i] == 0) ast[i] = 0; else acnt[i]--;
        endcase
      end
    end
    req = '0;
    n = 0;
    while (busy && n < 200) begin step(); n++; end
    chk("final_idle", busy, 0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
